// File: rtl/mux_arb_stream.sv
// mux_arb_stream: fixed/round-robin N:1 stream mux with a registered output slot; define MUX_ARB_STREAM_STATS_EN for per-channel transfer counters
module mux_arb_stream #(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_chan,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic [SEL_W-1:0]        stat_sel,
    output logic [15:0]             stat_count
);
    logic [SEL_W-1:0] ptr, rr_gnt, gnt;
    logic             rr_hit, fx_hit, hit, load_en, xfer;
    always_comb begin
        rr_hit = 1'b0;
        rr_gnt = '0;
        for (int k = NUM_IN; k >= 1; k--) begin
            if (in_valid[(int'(ptr) + k) % NUM_IN]) begin
                rr_hit = 1'b1;
                rr_gnt = SEL_W'((int'(ptr) + k) % NUM_IN);
            end
        end
    end
    always_comb begin
        fx_hit   = (int'(sel) < NUM_IN) && in_valid[sel];
        hit      = mode ? rr_hit : fx_hit;
        gnt      = mode ? rr_gnt : sel;
        load_en  = ~out_valid | out_ready;
        xfer     = rst_n & load_en & hit;
        in_ready = xfer ? NUM_IN'(1) << gnt : '0;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= SEL_W'(NUM_IN - 1);
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[int'(gnt)*WIDTH +: WIDTH];
            out_chan  <= gnt;
            ptr       <= gnt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
`ifdef MUX_ARB_STREAM_STATS_EN
    logic [15:0] cnt [NUM_IN];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_IN; i++) cnt[i] <= '0;
        end else if (xfer && cnt[gnt] != 16'hFFFF) begin
            cnt[gnt] <= cnt[gnt] + 16'd1;
        end
    end
    always_comb stat_count = (int'(stat_sel) < NUM_IN) ? cnt[stat_sel] : '0;
`else
    logic unused_stat;
    assign unused_stat = ^stat_sel;
    assign stat_count  = '0;
`endif
endmodule

// File: doc/mux_arb_stream.md
MUX_ARB_STREAM -- requirements
Module: mux_arb_stream

Interface
REQ-001 Parameter WIDTH, default 16, data bits per channel.
REQ-002 Parameter NUM_IN, default 4, input channel count; legal range 2..16.
REQ-003 Parameter SEL_W, default $clog2(NUM_IN), selector and channel-ID width.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  NUM_IN  per-channel valid.
REQ-008 in_ready  output  NUM_IN  per-channel ready; at most one bit high per cycle.
REQ-009 mode  input  1  0 = fixed select, 1 = round-robin arbitration.
REQ-010 sel  input  SEL_W  channel chosen in fixed mode.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_chan  output  SEL_W  channel index that sourced out_data.
REQ-013 out_valid  output  1  output register holds a word.
REQ-014 out_ready  input  1  downstream accepts the word.
REQ-015 stat_sel  input  SEL_W  channel whose transfer count is shown.
REQ-016 stat_count  output  16  transfer count of channel stat_sel.

Function
REQ-017 Transfer on an input: in_valid[i] & in_ready[i] in the same cycle; transfer on the output: out_valid & out_ready.
REQ-018 load_en = ~out_valid | out_ready; in_ready SHALL be all-zero when load_en is 0.
REQ-019 Fixed mode: grant = sel when in_valid[sel]=1; no grant otherwise, even if other channels are valid.
REQ-020 Fixed mode: sel >= NUM_IN SHALL produce no grant.
REQ-021 Round-robin mode: grant = first valid channel searching ptr+1, ptr+2, ... with wrap from NUM_IN-1 to 0; ptr itself is checked last.
REQ-022 in_ready[grant] = load_en; all other in_ready bits are 0.
REQ-023 On an input transfer, out_data <= granted channel data, out_chan <= grant, out_valid <= 1, and ptr <= grant, in either mode.
REQ-024 Output drain with no input transfer sets out_valid <= 0; out_data and out_chan hold.
REQ-025 A simultaneous drain and load in one cycle SHALL sustain throughput of one word per clock with no bubble.
REQ-026 While out_valid=1 and out_ready=0, out_data, out_chan and out_valid SHALL remain stable.
REQ-027 Latency is one clock from input transfer to out_valid.
REQ-028 mode and sel are sampled combinationally each cycle; a change takes effect on the next grant only, never on a held word.
REQ-029 ptr is retained across mode changes.
REQ-030 No valid input with load_en=1 SHALL leave ptr unchanged.

Reset
REQ-031 When rst_n=0 at a clk edge: out_valid=0, out_data=0, out_chan=0, ptr=NUM_IN-1, and all statistics counters=0.
REQ-032 in_ready SHALL be all-zero while rst_n=0.
REQ-033 Reset asserted mid-operation SHALL discard any held word; no transfer completes in that cycle.

Configuration
REQ-034 Macro MUX_ARB_STREAM_STATS_EN, when defined: one 16-bit counter per channel, incremented on each input transfer of that channel, saturating at 0xFFFF.
REQ-035 With the macro defined, stat_count = counter[stat_sel], combinational; stat_sel >= NUM_IN reads 0.
REQ-036 Without the macro: no counters are synthesised, stat_count is tied to 0, and ports are unchanged.

Verification
REQ-037 Reset, then mode=0, sel=2, in_valid=4'b0100, ch2=16'hBEEF, out_ready=1 -> next cycle out_valid=1, out_data=16'hBEEF, out_chan=2.
REQ-038 mode=1, in_valid=4'b1111 held, out_ready=1 from reset -> out_chan sequence 0,1,2,3,0, one word per clock.
REQ-039 mode=1, word held, out_ready=0 for 5 cycles -> in_ready=0 and out_data/out_chan stable; on out_ready=1, the next grant follows ptr.
REQ-040 mode=0, sel=1, in_valid=4'b1101 -> no grant, out_valid stays 0; switch to mode=1 -> grant to ch2 (ptr=1 after prior ch1 transfer).
REQ-041 rst_n=0 while out_valid=1 -> next cycle out_valid=0, out_chan=0, and the first round-robin grant is ch0.
REQ-042 With STATS_EN: 70000 ch3 transfers -> stat_sel=3 reads 16'hFFFF; stat_sel=0 reads 0.
